exe_task_dispatcher: RTL and testbench
======================================

# exe_task_dispatcher

Host-side initiator for the execution unit's start/finish protocol. It buffers microcode entry addresses from the host in a small FIFO, launches one task at a time by pulsing the unit's trigger with a stable initial code address, then waits for the done pulse. It captures the return code and presents a result record to the host through a valid/ready handshake. It sits between the host/bus controller and the execution unit's `iTrigger`/`iInitialCodeAddress`/`oDone`/`oReturnCode` pins.

## Interface
Parameters:
- `FIFO_DEPTH`, 4 — task FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 65535 — watchdog limit in cycles; used only with the watchdog compiled in.

Ports:
- `Clock` in 1 — single clock.
- `Reset` in 1 — synchronous, active-high.
- `iTaskValid` in 1 — host offers an entry address.
- `iTaskAddress` in `ROM_ADDRESS_WIDTH` — microcode entry address.
- `oTaskReady` out 1 — FIFO not full; a task is accepted when `iTaskValid && oTaskReady` at a clock edge.
- `oTrigger` out 1 — one-cycle start pulse to the execution unit.
- `oInitialCodeAddress` out `ROM_ADDRESS_WIDTH` — entry address of the task in flight.
- `iExeDone` in 1 — completion pulse from the execution unit.
- `iExeReturnCode` in 1 — return value, sampled with `iExeDone`.
- `oResultValid` out 1 — result record available.
- `iResultReady` in 1 — host consumes the record.
- `oResultAddress` out `ROM_ADDRESS_WIDTH` — entry address of the finished task.
- `oResultCode` out 1 — captured return code.
- `oResultTimeout` out 1 — task ended by watchdog.
- `oExeAbort` out 1 — one-cycle pulse requesting an external execution-unit reset.
- `oBusy` out 1 — state ≠ IDLE or FIFO non-empty.
- `oCompletedCount` out 8 — tasks reported; wraps at 255→0.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, REPORT.
- **IDLE:**
  - If the FIFO is non-empty: pop the head into the address register, go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH:** `oTrigger`=1 for exactly this cycle. `iExeDone` is ignored in this cycle. Go to WAIT.
- **WAIT:**
  - On `iExeDone`=1: latch `oResultCode`←`iExeReturnCode`, `oResultAddress`←address register, `oResultTimeout`←0. Go to REPORT.
- **REPORT:**
  - `oResultValid`=1; record fields held stable.
  - On `iResultReady`=1: increment `oCompletedCount`, go to IDLE. The next launch never overlaps an unconsumed result.
- `iExeDone` in IDLE or REPORT is ignored and produces no record.
- FIFO:
  - Push when `iTaskValid && oTaskReady`.
  - `oTaskReady`=0 when count==`FIFO_DEPTH`, so a push while full is dropped by protocol.
  - A simultaneous push and pop (IDLE pop) in any non-full state is legal; count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`; count width is clog2(`FIFO_DEPTH`)+1.
- `oInitialCodeAddress` is driven from the address register, stable from LAUNCH through REPORT.
- Reset values:
  - State IDLE, FIFO empty.
  - `oTaskReady`=1 (first cycle after reset deassertion).
  - `oTrigger`=0, `oResultValid`=0, `oResultCode`=0, `oResultTimeout`=0, `oExeAbort`=0, `oBusy`=0, `oCompletedCount`=0.
  - `oInitialCodeAddress`=0, `oResultAddress`=0.
- Reset asserted mid-task discards the FIFO and the in-flight task; no abort pulse is generated.

## Timing
- Task accepted at edge N into an empty FIFO while IDLE: pop at edge N+1, then `oTrigger` high between edges N+1 and N+2.
- `iExeDone` sampled at edge D in WAIT: `oResultValid` high from D onward.
- Record consumed at edge C: IDLE after C; the next `oTrigger` is high between C+1 and C+2 if the FIFO is non-empty.
- Minimum launch-to-launch interval is 4 cycles plus the execution time.
- All outputs are registered except `oTaskReady` and `oBusy`, which are combinational from registered state and count.

## Configuration
- Macro `EXE_DISPATCH_WATCHDOG_EN`.
- **Defined:**
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `iExeDone`: `oExeAbort` pulses for 1 cycle, and the FSM goes to REPORT with `oResultTimeout`=1 and `oResultCode`=0.
  - If `iExeDone` and the timeout coincide, done wins: no abort, timeout=0.
- **Undefined:** no counter; `oExeAbort` and `oResultTimeout` are tied to 0; WAIT persists indefinitely.

## Structure
- Shared package/definitions file holds:
  - FSM state encodings, e.g. `EXD_IDLE`..`EXD_REPORT`.
  - `ROM_ADDRESS_WIDTH`, via the existing definitions include.
- One sub-module, `exe_task_fifo`: synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width.
- FSM, address register, result register and watchdog live in the top.

## Test plan
- After reset: push 0x0040 → `oTrigger` one cycle, `oInitialCodeAddress`=0x0040. Then `iExeDone`=1 with `iExeReturnCode`=1 → record {0x0040, code 1, timeout 0}, and `oCompletedCount`=1 after `iResultReady`.
- Push 5 tasks back-to-back with `FIFO_DEPTH`=4 while one task is in WAIT → `oTaskReady` drops after the 4th buffered task. Completing the tasks in order yields records 0x10,0x20,0x30,0x40,0x50 in order.
- Hold `iResultReady`=0 for 10 cycles with 2 tasks queued → no further `oTrigger`, and the record stays stable until ready.
- Spurious `iExeDone` in IDLE and in LAUNCH → no record, `oCompletedCount` unchanged.
- With `EXE_DISPATCH_WATCHDOG_EN`, `TIMEOUT_CYCLES`=8, no done → `oExeAbort` pulses 8 cycles after WAIT entry, and the record has timeout=1, code=0.
- Reset asserted during WAIT with 3 tasks queued → all outputs return to reset values next cycle, and no trigger follows.

Source files
------------

// File: rtl/exe_task_dispatcher_pkg.sv
// Shared definitions for the execution-unit task dispatcher: address width,
// FSM state encoding and a small state-classification helper.
package exe_task_dispatcher_pkg;

    localparam int ROM_ADDRESS_WIDTH = 16;

    typedef enum logic [1:0] {
        EXD_IDLE   = 2'd0,
        EXD_LAUNCH = 2'd1,
        EXD_WAIT   = 2'd2,
        EXD_REPORT = 2'd3
    } exdState_t;

    function automatic logic isActive(input exdState_t state);
        return (state != EXD_IDLE);
    endfunction

endpackage

// File: rtl/exe_task_fifo.sv
// Synchronous FIFO buffering task entry addresses; DEPTH must be a power of two.
module exe_task_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wrPtr_r;
    logic [PW-1:0]    rdPtr_r;
    logic [PW:0]      count_r;
    logic             pushEn_s;
    logic             popEn_s;

    assign full     = (count_r == (PW+1)'(DEPTH));
    assign empty    = (count_r == {(PW+1){1'b0}});
    assign count    = count_r;
    assign popData  = mem_r[rdPtr_r];
    assign pushEn_s = push && !full;
    assign popEn_s  = pop && !empty;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else begin
            if (pushEn_s) begin
                wrPtr_r <= wrPtr_r + PW'(1);
            end
            if (popEn_s) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            case ({pushEn_s, popEn_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge Clock) begin
        if (pushEn_s) begin
            mem_r[wrPtr_r] <= pushData;
        end
    end

endmodule

// File: rtl/exe_task_dispatcher.sv
// Launches buffered tasks on the execution unit one at a time and reports results.
// Optional watchdog abort compiled in with `define EXE_DISPATCH_WATCHDOG_EN.
module exe_task_dispatcher
    import exe_task_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iTaskValid,
    input  logic [ROM_ADDRESS_WIDTH-1:0] iTaskAddress,
    output logic                         oTaskReady,
    output logic                         oTrigger,
    output logic [ROM_ADDRESS_WIDTH-1:0] oInitialCodeAddress,
    input  logic                         iExeDone,
    input  logic                         iExeReturnCode,
    output logic                         oResultValid,
    input  logic                         iResultReady,
    output logic [ROM_ADDRESS_WIDTH-1:0] oResultAddress,
    output logic                         oResultCode,
    output logic                         oResultTimeout,
    output logic                         oExeAbort,
    output logic                         oBusy,
    output logic [7:0]                   oCompletedCount
);

    exdState_t                    state_r;
    exdState_t                    stateNext_s;
    logic                         pop_s;
    logic                         doneTake_s;
    logic                         timeoutTake_s;
    logic                         wdExpired_s;
    logic                         fifoFull_s;
    logic                         fifoEmpty_s;
    logic [ROM_ADDRESS_WIDTH-1:0] fifoHead_s;
    logic [$clog2(FIFO_DEPTH):0]  fifoCount_s;
    logic [ROM_ADDRESS_WIDTH-1:0] addressReg_r;
    logic                         trigger_r;
    logic                         resultValid_r;
    logic [ROM_ADDRESS_WIDTH-1:0] resultAddress_r;
    logic                         resultCode_r;
    logic                         resultTimeout_r;
    logic                         exeAbort_r;
    logic [7:0]                   completedCount_r;
    logic                         unusedCount_s;

    exe_task_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ROM_ADDRESS_WIDTH)
    ) u_fifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .push     (iTaskValid),
        .pushData (iTaskAddress),
        .pop      (pop_s),
        .popData  (fifoHead_s),
        .full     (fifoFull_s),
        .empty    (fifoEmpty_s),
        .count    (fifoCount_s)
    );

    assign unusedCount_s = ^fifoCount_s;

`ifdef EXE_DISPATCH_WATCHDOG_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_WIDTH-1:0] wdCount_r;

    // Watchdog cycle counter, cleared as the FSM enters WAIT.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wdCount_r <= {WD_WIDTH{1'b0}};
        end else if (state_r == EXD_LAUNCH) begin
            wdCount_r <= {WD_WIDTH{1'b0}};
        end else if (state_r == EXD_WAIT) begin
            wdCount_r <= wdCount_r + WD_WIDTH'(1);
        end
    end

    // Expiry is flagged in the last allowed WAIT cycle so the abort lands exactly TIMEOUT_CYCLES after entry.
    assign wdExpired_s = (state_r == EXD_WAIT) && (wdCount_r == WD_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    logic unusedTimeout_s;

    assign unusedTimeout_s = (TIMEOUT_CYCLES > 0);
    assign wdExpired_s     = 1'b0;
`endif

    // Next-state and per-cycle control decisions.
    always_comb begin
        stateNext_s   = state_r;
        pop_s         = 1'b0;
        doneTake_s    = 1'b0;
        timeoutTake_s = 1'b0;
        case (state_r)
            EXD_IDLE: begin
                if (!fifoEmpty_s) begin
                    pop_s       = 1'b1;
                    stateNext_s = EXD_LAUNCH;
                end else begin
                    stateNext_s = EXD_IDLE;
                end
            end
            EXD_LAUNCH: begin
                stateNext_s = EXD_WAIT;
            end
            EXD_WAIT: begin
                // A done pulse coinciding with expiry takes priority.
                if (iExeDone) begin
                    doneTake_s  = 1'b1;
                    stateNext_s = EXD_REPORT;
                end else if (wdExpired_s) begin
                    timeoutTake_s = 1'b1;
                    stateNext_s   = EXD_REPORT;
                end else begin
                    stateNext_s = EXD_WAIT;
                end
            end
            EXD_REPORT: begin
                if (iResultReady) begin
                    stateNext_s = EXD_IDLE;
                end else begin
                    stateNext_s = EXD_REPORT;
                end
            end
            default: begin
                stateNext_s = EXD_IDLE;
            end
        endcase
    end

    // State, address, result record and registered handshake outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r          <= EXD_IDLE;
            addressReg_r     <= {ROM_ADDRESS_WIDTH{1'b0}};
            trigger_r        <= 1'b0;
            resultValid_r    <= 1'b0;
            resultAddress_r  <= {ROM_ADDRESS_WIDTH{1'b0}};
            resultCode_r     <= 1'b0;
            resultTimeout_r  <= 1'b0;
            exeAbort_r       <= 1'b0;
            completedCount_r <= 8'd0;
        end else begin
            state_r       <= stateNext_s;
            trigger_r     <= (stateNext_s == EXD_LAUNCH);
            resultValid_r <= (stateNext_s == EXD_REPORT);
            exeAbort_r    <= timeoutTake_s;
            if (pop_s) begin
                addressReg_r <= fifoHead_s;
            end
            if (doneTake_s) begin
                resultAddress_r <= addressReg_r;
                resultCode_r    <= iExeReturnCode;
                resultTimeout_r <= 1'b0;
            end else if (timeoutTake_s) begin
                resultAddress_r <= addressReg_r;
                resultCode_r    <= 1'b0;
                resultTimeout_r <= 1'b1;
            end
            if ((state_r == EXD_REPORT) && iResultReady) begin
                completedCount_r <= completedCount_r + 8'd1;
            end
        end
    end

    assign oTaskReady          = !fifoFull_s;
    assign oBusy               = isActive(state_r) || !fifoEmpty_s;
    assign oTrigger            = trigger_r;
    assign oInitialCodeAddress = addressReg_r;
    assign oResultValid        = resultValid_r;
    assign oResultAddress      = resultAddress_r;
    assign oResultCode         = resultCode_r;
    assign oResultTimeout      = resultTimeout_r;
    assign oExeAbort           = exeAbort_r;
    assign oCompletedCount     = completedCount_r;

endmodule

// File: tb/tb_exe_task_dispatcher.sv
// Directed self-checking bench for exe_task_dispatcher (FIFO_DEPTH=4, TIMEOUT_CYCLES=8).
module tb_exe_task_dispatcher;
    import exe_task_dispatcher_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iTaskValid;
    logic [15:0] iTaskAddress;
    logic        oTaskReady;
    logic        oTrigger;
    logic [15:0] oInitialCodeAddress;
    logic        iExeDone;
    logic        iExeReturnCode;
    logic        oResultValid;
    logic        iResultReady;
    logic [15:0] oResultAddress;
    logic        oResultCode;
    logic        oResultTimeout;
    logic        oExeAbort;
    logic        oBusy;
    logic [7:0]  oCompletedCount;

    int compared = 0;
    int mismatched = 0;

    logic [18:0] rec;
    logic [46:0] allOut;
    assign rec    = {oResultValid, oResultAddress, oResultCode, oResultTimeout};
    assign allOut = {oTaskReady, oTrigger, oResultValid, oResultCode, oResultTimeout, oExeAbort,
                     oBusy, oCompletedCount, oInitialCodeAddress, oResultAddress};

    localparam logic [46:0] RESET_VEC = {1'b1, 6'b000000, 8'd0, 16'h0000, 16'h0000};

    exe_task_dispatcher #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .iTaskValid          (iTaskValid),
        .iTaskAddress        (iTaskAddress),
        .oTaskReady          (oTaskReady),
        .oTrigger            (oTrigger),
        .oInitialCodeAddress (oInitialCodeAddress),
        .iExeDone            (iExeDone),
        .iExeReturnCode      (iExeReturnCode),
        .oResultValid        (oResultValid),
        .iResultReady        (iResultReady),
        .oResultAddress      (oResultAddress),
        .oResultCode         (oResultCode),
        .oResultTimeout      (oResultTimeout),
        .oExeAbort           (oExeAbort),
        .oBusy               (oBusy),
        .oCompletedCount     (oCompletedCount)
    );

    always #5 Clock = ~Clock;

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        compared++;
        if (allOut !== RESET_VEC) begin
            mismatched++;
            $display("FAIL reset_state: got %h expected %h", allOut, RESET_VEC);
        end
        @(negedge Clock);
        compared++;
        if (allOut !== RESET_VEC) begin
            mismatched++;
            $display("FAIL reset_idle_hold: got %h expected %h", allOut, RESET_VEC);
        end
    endtask

    task automatic test_basic();
        iTaskValid = 1'b1; iTaskAddress = 16'h0040;
        @(negedge Clock);
        iTaskValid = 1'b0;
        compared++;
        if ({oTrigger, oBusy} !== 2'b01) begin
            mismatched++;
            $display("FAIL basic_accept: got %b expected 01", {oTrigger, oBusy});
        end
        @(negedge Clock);
        compared++;
        if ({oTrigger, oInitialCodeAddress} !== {1'b1, 16'h0040}) begin
            mismatched++;
            $display("FAIL basic_launch: got %h expected %h", {oTrigger, oInitialCodeAddress}, {1'b1, 16'h0040});
        end
        @(negedge Clock);
        compared++;
        if ({oTrigger, oInitialCodeAddress} !== {1'b0, 16'h0040}) begin
            mismatched++;
            $display("FAIL basic_trigger_pulse: got %h expected %h", {oTrigger, oInitialCodeAddress}, {1'b0, 16'h0040});
        end
        iExeDone = 1'b1; iExeReturnCode = 1'b1;
        @(negedge Clock);
        iExeDone = 1'b0; iExeReturnCode = 1'b0;
        compared++;
        if (rec !== {1'b1, 16'h0040, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL basic_record: got %h expected %h", rec, {1'b1, 16'h0040, 1'b1, 1'b0});
        end
        iResultReady = 1'b1;
        @(negedge Clock);
        iResultReady = 1'b0;
        compared++;
        if ({oResultValid, oCompletedCount, oBusy} !== {1'b0, 8'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL basic_consume: got %h expected %h", {oResultValid, oCompletedCount, oBusy}, {1'b0, 8'd1, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expAddr;
        logic        expCode;
        for (int i = 0; i < 5; i++) begin
            iTaskValid = 1'b1; iTaskAddress = 16'((i + 1) * 16);
            @(negedge Clock);
            if (i == 3) begin
                compared++;
                if (oTaskReady !== 1'b1) begin
                    mismatched++;
                    $display("FAIL b2b_ready_three_buffered: got %b expected 1", oTaskReady);
                end
            end
        end
        compared++;
        if ({oTaskReady, oInitialCodeAddress} !== {1'b0, 16'h0010}) begin
            mismatched++;
            $display("FAIL b2b_full: got %h expected %h", {oTaskReady, oInitialCodeAddress}, {1'b0, 16'h0010});
        end
        iTaskAddress = 16'h0060;
        @(negedge Clock);
        iTaskValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expAddr = 16'((i + 1) * 16);
            expCode = (i % 2 == 1);
            iExeDone = 1'b1; iExeReturnCode = expCode;
            @(negedge Clock);
            iExeDone = 1'b0; iExeReturnCode = 1'b0;
            compared++;
            if (rec !== {1'b1, expAddr, expCode, 1'b0}) begin
                mismatched++;
                $display("FAIL b2b_record_%0d: got %h expected %h", i, rec, {1'b1, expAddr, expCode, 1'b0});
            end
            iResultReady = 1'b1;
            @(negedge Clock);
            iResultReady = 1'b0;
            compared++;
            if (oCompletedCount !== 8'(2 + i)) begin
                mismatched++;
                $display("FAIL b2b_count_%0d: got %0d expected %0d", i, oCompletedCount, 2 + i);
            end
            if (i < 4) begin
                @(negedge Clock);
                compared++;
                if ({oTrigger, oInitialCodeAddress} !== {1'b1, 16'((i + 2) * 16)}) begin
                    mismatched++;
                    $display("FAIL b2b_launch_%0d: got %h expected %h", i + 1, {oTrigger, oInitialCodeAddress}, {1'b1, 16'((i + 2) * 16)});
                end
                @(negedge Clock);
            end
        end
        repeat (2) @(negedge Clock);
        compared++;
        if ({oTrigger, oBusy, oResultValid} !== 3'b000) begin
            mismatched++;
            $display("FAIL b2b_dropped_push: got %b expected 000", {oTrigger, oBusy, oResultValid});
        end
    endtask

    task automatic test_hold_ready();
        for (int i = 0; i < 3; i++) begin
            iTaskValid = 1'b1; iTaskAddress = 16'(16'h00A1 + i);
            @(negedge Clock);
        end
        iTaskValid = 1'b0;
        iExeDone = 1'b1; iExeReturnCode = 1'b0;
        @(negedge Clock);
        iExeDone = 1'b0;
        for (int k = 0; k < 10; k++) begin
            compared++;
            if ({oTrigger, rec} !== {1'b0, 1'b1, 16'h00A1, 1'b0, 1'b0}) begin
                mismatched++;
                $display("FAIL hold_stable_%0d: got %h expected %h", k, {oTrigger, rec}, {1'b0, 1'b1, 16'h00A1, 1'b0, 1'b0});
            end
            @(negedge Clock);
        end
        iResultReady = 1'b1;
        @(negedge Clock);
        iResultReady = 1'b0;
        compared++;
        if ({oResultValid, oCompletedCount} !== {1'b0, 8'd7}) begin
            mismatched++;
            $display("FAIL hold_consume: got %h expected %h", {oResultValid, oCompletedCount}, {1'b0, 8'd7});
        end
        @(negedge Clock);
        compared++;
        if ({oTrigger, oInitialCodeAddress} !== {1'b1, 16'h00A2}) begin
            mismatched++;
            $display("FAIL hold_next_launch: got %h expected %h", {oTrigger, oInitialCodeAddress}, {1'b1, 16'h00A2});
        end
        @(negedge Clock);
        iExeDone = 1'b1; iExeReturnCode = 1'b1;
        @(negedge Clock);
        iExeDone = 1'b0; iExeReturnCode = 1'b0;
        compared++;
        if (rec !== {1'b1, 16'h00A2, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL hold_record_a2: got %h expected %h", rec, {1'b1, 16'h00A2, 1'b1, 1'b0});
        end
        iResultReady = 1'b1;
        @(negedge Clock);
        iResultReady = 1'b0;
        @(negedge Clock);
        compared++;
        if ({oTrigger, oInitialCodeAddress} !== {1'b1, 16'h00A3}) begin
            mismatched++;
            $display("FAIL hold_launch_a3: got %h expected %h", {oTrigger, oInitialCodeAddress}, {1'b1, 16'h00A3});
        end
        @(negedge Clock);
        iExeDone = 1'b1;
        @(negedge Clock);
        iExeDone = 1'b0;
        iResultReady = 1'b1;
        @(negedge Clock);
        iResultReady = 1'b0;
        compared++;
        if ({oCompletedCount, oBusy} !== {8'd9, 1'b0}) begin
            mismatched++;
            $display("FAIL hold_drain: got %h expected %h", {oCompletedCount, oBusy}, {8'd9, 1'b0});
        end
    endtask

    task automatic test_spurious_done();
        iExeDone = 1'b1; iExeReturnCode = 1'b1;
        repeat (2) @(negedge Clock);
        iExeDone = 1'b0; iExeReturnCode = 1'b0;
        @(negedge Clock);
        compared++;
        if ({oResultValid, oCompletedCount} !== {1'b0, 8'd9}) begin
            mismatched++;
            $display("FAIL spurious_idle: got %h expected %h", {oResultValid, oCompletedCount}, {1'b0, 8'd9});
        end
        iTaskValid = 1'b1; iTaskAddress = 16'h00B0;
        @(negedge Clock);
        iTaskValid = 1'b0;
        @(negedge Clock);
        iExeDone = 1'b1;
        @(negedge Clock);
        iExeDone = 1'b0;
        repeat (2) @(negedge Clock);
        compared++;
        if ({oResultValid, oCompletedCount, oInitialCodeAddress} !== {1'b0, 8'd9, 16'h00B0}) begin
            mismatched++;
            $display("FAIL spurious_launch: got %h expected %h", {oResultValid, oCompletedCount, oInitialCodeAddress}, {1'b0, 8'd9, 16'h00B0});
        end
        iExeDone = 1'b1; iExeReturnCode = 1'b1;
        @(negedge Clock);
        iExeDone = 1'b0; iExeReturnCode = 1'b0;
        compared++;
        if (rec !== {1'b1, 16'h00B0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL spurious_real_done: got %h expected %h", rec, {1'b1, 16'h00B0, 1'b1, 1'b0});
        end
        iResultReady = 1'b1;
        @(negedge Clock);
        iResultReady = 1'b0;
        compared++;
        if (oCompletedCount !== 8'd10) begin
            mismatched++;
            $display("FAIL spurious_count: got %0d expected 10", oCompletedCount);
        end
    endtask

`ifdef EXE_DISPATCH_WATCHDOG_EN
    task automatic test_watchdog();
        iTaskValid = 1'b1; iTaskAddress = 16'h00C0;
        @(negedge Clock);
        iTaskValid = 1'b0;
        @(negedge Clock);
        iExeReturnCode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            compared++;
            if ({oExeAbort, oResultValid} !== 2'b00) begin
                mismatched++;
                $display("FAIL wd_early_%0d: got %b expected 00", k, {oExeAbort, oResultValid});
            end
        end
        @(negedge Clock);
        compared++;
        if ({oExeAbort, rec} !== {1'b1, 1'b1, 16'h00C0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL wd_abort: got %h expected %h", {oExeAbort, rec}, {1'b1, 1'b1, 16'h00C0, 1'b0, 1'b1});
        end
        iExeReturnCode = 1'b0;
        @(negedge Clock);
        compared++;
        if ({oExeAbort, oResultValid} !== 2'b01) begin
            mismatched++;
            $display("FAIL wd_abort_pulse: got %b expected 01", {oExeAbort, oResultValid});
        end
        iResultReady = 1'b1;
        @(negedge Clock);
        iResultReady = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_task();
        for (int i = 0; i < 4; i++) begin
            iTaskValid = 1'b1; iTaskAddress = 16'(16'h00D1 + i);
            @(negedge Clock);
        end
        iTaskValid = 1'b0;
        compared++;
        if ({oBusy, oInitialCodeAddress} !== {1'b1, 16'h00D1}) begin
            mismatched++;
            $display("FAIL rst_mid_setup: got %h expected %h", {oBusy, oInitialCodeAddress}, {1'b1, 16'h00D1});
        end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        compared++;
        if (allOut !== RESET_VEC) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: got %h expected %h", allOut, RESET_VEC);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            compared++;
            if ({oTrigger, oBusy, oExeAbort} !== 3'b000) begin
                mismatched++;
                $display("FAIL rst_mid_no_trigger_%0d: got %b expected 000", k, {oTrigger, oBusy, oExeAbort});
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        iTaskValid = 1'b0;
        iTaskAddress = 16'h0000;
        iExeDone = 1'b0;
        iExeReturnCode = 1'b0;
        iResultReady = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold_ready();
        test_spurious_done();
`ifdef EXE_DISPATCH_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_task();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
